// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, detects mispredictions,
// holds a fetch redirect until it is consumed, trains a 2-bit-counter BHT and
// keeps branch / mispredict statistics.
module branch_resolve_unit #(
    parameter int AW        = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_branch,
    input  logic [2:0]    in_cond,
    input  logic          in_zf,
    input  logic          in_lf,
    input  logic [AW-1:0] in_pc,
    input  logic [AW-1:0] in_target,
    input  logic          in_pred_taken,
    input  logic [AW-1:0] in_pred_target,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc,
    input  logic          redirect_ready,
    output logic          flush,
    input  logic [AW-1:0] lu_pc,
    output logic          lu_taken,
    output logic [31:0]   branch_cnt,
    output logic [31:0]   mispred_cnt
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic                          r_redirect_valid;
    logic [AW-1:0]                 r_redirect_pc;
    logic [BHT_DEPTH-1:0][1:0]     r_bht;
    logic [31:0]                   r_branch_cnt;
    logic [31:0]                   r_mispred_cnt;

    logic          w_accept;
    logic          w_cond_true;
    logic          w_taken;
    logic          w_mispred;
    logic [AW-1:0] w_next_pc;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_lu_idx;
    logic [1:0]    w_cur_ctr;
    logic [1:0]    w_new_ctr;
    logic          w_unused;

    // Decode the condition code against the compare flags.
    always_comb begin
        w_cond_true = 1'b1;
        case (in_cond)
            3'b001:  w_cond_true = in_zf;
            3'b010:  w_cond_true = !in_zf;
            3'b011:  w_cond_true = !in_lf;
            3'b100:  w_cond_true = !in_zf && !in_lf;
            3'b101:  w_cond_true = in_zf || in_lf;
            3'b110:  w_cond_true = in_lf;
            default: w_cond_true = 1'b1;
        endcase
    end

    // Resolve direction, correct next PC (pc+8 skips the delay slot) and
    // compare against the front-end prediction.
    always_comb begin
        w_accept  = in_valid && !r_redirect_valid;
        w_taken   = in_branch && w_cond_true;
        w_next_pc = w_taken ? in_target : in_pc + AW'(8);
        w_mispred = in_branch &&
                    ((w_taken != in_pred_taken) ||
                     (w_taken && in_pred_taken && (in_target != in_pred_target)));
    end

    // Saturating counter next value for the entry of the branch being resolved.
    always_comb begin
        w_wr_idx  = in_pc[IW+1:2];
        w_lu_idx  = lu_pc[IW+1:2];
        w_cur_ctr = r_bht[w_wr_idx];
        w_new_ctr = w_cur_ctr;
        if (w_taken) begin
            if (w_cur_ctr != 2'b11) w_new_ctr = w_cur_ctr + 2'b01;
        end else begin
            if (w_cur_ctr != 2'b00) w_new_ctr = w_cur_ctr - 2'b01;
        end
    end

    // Redirect register: set by a mispredicted accept, held until fetch consumes it.
    // New requests are blocked while it is pending, so set and clear never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (w_accept && w_mispred) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_next_pc;
        end else if (r_redirect_valid && redirect_ready) begin
            r_redirect_valid <= 1'b0;
        end
    end

    // BHT training; all entries start weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bht <= {BHT_DEPTH{2'b01}};
        end else if (w_accept && in_branch) begin
            r_bht[w_wr_idx] <= w_new_ctr;
        end
    end

    // Statistics counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept && in_branch) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    // Output drive; lookup reads the registered table so an in-flight update
    // is not visible until the following cycle.
    always_comb begin
        in_ready       = !r_redirect_valid;
        redirect_valid = r_redirect_valid;
        redirect_pc    = r_redirect_pc;
        flush          = r_redirect_valid && redirect_ready;
        lu_taken       = r_bht[w_lu_idx][1];
        branch_cnt     = r_branch_cnt;
        mispred_cnt    = r_mispred_cnt;
    end

    // Lookup address bits outside the table index are intentionally ignored.
    assign w_unused = &{1'b0, lu_pc[AW-1:IW+2], lu_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_branch_resolve_unit;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_branch = 1'b0, in_zf = 1'b0, in_lf = 1'b0;
    logic [2:0]    in_cond = '0;
    logic [AW-1:0] in_pc = '0, in_target = '0, in_pred_target = '0, lu_pc = '0;
    logic          in_pred_taken = 1'b0, redirect_ready = 1'b0;
    logic          in_ready, redirect_valid, flush, lu_taken;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   branch_cnt, mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_bht[DEPTH];
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_bcnt, m_mcnt;

    branch_resolve_unit #(.AW(AW), .BHT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_branch(in_branch),
        .in_cond(in_cond), .in_zf(in_zf), .in_lf(in_lf),
        .in_pc(in_pc), .in_target(in_target),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush),
        .lu_pc(lu_pc), .lu_taken(lu_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [2:0] c, input logic zf, input logic lf);
        case (c)
            3'd1: return zf;
            3'd2: return !zf;
            3'd3: return !lf;
            3'd4: return !zf && !lf;
            3'd5: return zf || lf;
            3'd6: return lf;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Compare all observable outputs with the model, then advance the model
    // by one clock using the inputs present now, then move to the next cycle.
    task automatic step();
        bit taken, misp;
        logic [31:0] nxt;
        #1;
        chk("in_ready", in_ready, !m_rv);
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush", flush, m_rv && redirect_ready);
        chk("lu_taken", lu_taken, m_bht[idx_of(lu_pc)] >= 2);
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispred_cnt", mispred_cnt, m_mcnt);

        taken = in_branch && cond_holds(in_cond, in_zf, in_lf);
        nxt   = taken ? in_target : in_pc + 32'd8;
        misp  = in_branch && ((taken != in_pred_taken) ||
                (taken && in_pred_taken && in_target != in_pred_target));
        if (m_rv) begin
            if (redirect_ready) m_rv = 1'b0;
        end else if (in_valid) begin
            if (in_branch) begin
                m_bcnt++;
                if (misp) m_mcnt++;
                if (taken) m_bht[idx_of(in_pc)] = (m_bht[idx_of(in_pc)] == 3) ? 3 : m_bht[idx_of(in_pc)] + 1;
                else       m_bht[idx_of(in_pc)] = (m_bht[idx_of(in_pc)] == 0) ? 0 : m_bht[idx_of(in_pc)] - 1;
            end
            if (misp) begin
                m_rv  = 1'b1;
                m_rpc = nxt;
            end
        end
        @(negedge clk);
    endtask

    // Reset pulse issued between edges: outputs must clear immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_rv = 1'b0; m_rpc = '0; m_bcnt = '0; m_mcnt = '0;
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_branch_cnt", branch_cnt, 32'h0);
        chk("rst_mispred_cnt", mispred_cnt, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            lu_pc = 32'(i) << 2;
            #1 chk("rst_lu_taken", lu_taken, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic b, input logic [2:0] c, input logic zf, input logic lf,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
        in_valid = 1'b1; in_branch = b; in_cond = c; in_zf = zf; in_lf = lf;
        in_pc = pc; in_target = tgt; in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // taken-but-predicted-not-taken branch
        redirect_ready = 1'b0;
        drive(1, 3'b001, 1, 0, 32'h100, 32'h200, 0, 32'h0);
        step();
        idle(1);
        chk("d1_rpc", redirect_pc, 32'h200);
        redirect_ready = 1'b1; idle(2);

        // not-taken predicted taken, redirect held while in_valid is ignored
        redirect_ready = 1'b0;
        drive(1, 3'b100, 0, 1, 32'h100, 32'h200, 1, 32'h200);
        step();
        drive(1, 3'b000, 0, 0, 32'h300, 32'h400, 0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("d2_rpc", redirect_pc, 32'h108);
        redirect_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // correct prediction, then wrong target
        do_reset();
        redirect_ready = 1'b1;
        drive(1, 3'b000, 0, 0, 32'h100, 32'h200, 1, 32'h200);
        step();
        drive(1, 3'b000, 0, 0, 32'h100, 32'h200, 1, 32'h204);
        step();
        idle(2);

        // BHT training on one entry
        do_reset();
        lu_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'b111, 0, 0, 32'h40, 32'h80, 1, 32'h80);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 3'b001, 0, 0, 32'h40, 32'h80, 0, 32'h0);
            step();
        end
        idle(1);
        chk("d4_lu_taken", lu_taken, 1'b0);

        // fall-through address wraps
        redirect_ready = 1'b0;
        drive(1, 3'b110, 0, 0, 32'hFFFF_FFFC, 32'h1000, 1, 32'h1000);
        step();
        idle(1);
        chk("d5_rpc_wrap", redirect_pc, 32'h4);

        // reset while a redirect is pending with fetch ready
        redirect_ready = 1'b1;
        do_reset();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, tgt;
            pc  = ({$urandom_range(0, 3)} << 28) | ({$urandom_range(0, 7)} << 2);
            tgt = $urandom_range(0, 15) << 2;
            in_valid       = ($urandom_range(0, 3) != 0);
            in_branch      = ($urandom_range(0, 4) != 0);
            in_cond        = 3'($urandom);
            in_zf          = 1'($urandom);
            in_lf          = 1'($urandom);
            in_pc          = pc;
            in_target      = tgt;
            in_pred_taken  = 1'($urandom);
            in_pred_target = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
            redirect_ready = 1'($urandom);
            lu_pc          = $urandom_range(0, 7) << 2;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter AW, 32, address/target width in bits.
REQ-002 Parameter BHT_DEPTH, 64, branch-history-table entries; power of 2, minimum 2; IW = log2(BHT_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  resolve request present.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 in_branch  input  1  request is a branch/jump.
REQ-008 in_cond  input  3  condition code: 000 always; 001 zf; 010 !zf; 011 !lf; 100 !zf&!lf; 101 zf|lf; 110 lf; 111 always.
REQ-009 in_zf, in_lf  input  1 each  zero flag and less-than flag of the branch compare.
REQ-010 in_pc  input  AW  address of the branch instruction.
REQ-011 in_target  input  AW  computed taken target.
REQ-012 in_pred_taken, in_pred_target  input  1 / AW  front-end prediction.
REQ-013 redirect_valid  output  1  fetch redirect pending.
REQ-014 redirect_pc  output  AW  correct next fetch address.
REQ-015 redirect_ready  input  1  fetch consumes redirect.
REQ-016 flush  output  1  one-cycle squash of younger instructions.
REQ-017 lu_pc  input  AW  BHT lookup address.
REQ-018 lu_taken  output  1  BHT prediction for lu_pc.
REQ-019 branch_cnt, mispred_cnt  output  32 each  statistics counters.

Function
REQ-020 Accept = in_valid & in_ready; in_ready SHALL equal !redirect_valid.
REQ-021 Resolved taken SHALL be in_branch & (condition per REQ-008 true).
REQ-022 Correct next PC SHALL be in_target if taken, else in_pc + 8 (delay slot), modulo 2^AW.
REQ-023 Mispredict SHALL be in_branch & ((taken != in_pred_taken) | (taken & in_pred_taken & in_target != in_pred_target)).
REQ-024 On accept with mispredict, redirect_valid SHALL assert the next cycle with redirect_pc = correct next PC; no redirect for non-branches or correct predictions.
REQ-025 redirect_valid and redirect_pc SHALL hold stable until the cycle redirect_ready=1, then clear next cycle.
REQ-026 flush SHALL equal redirect_valid & redirect_ready (exactly one cycle per redirect).
REQ-027 While redirect_valid=1, in_valid SHALL be ignored (no BHT or counter update).
REQ-028 BHT SHALL hold BHT_DEPTH 2-bit saturating counters indexed by pc[IW+1:2].
REQ-029 On accept of a branch: taken increments (saturate 11), not-taken decrements (saturate 00); write visible the following cycle.
REQ-030 lu_taken SHALL be combinational bit[1] of the entry at lu_pc[IW+1:2]; same-cycle lookup of an entry being updated returns the old value.
REQ-031 branch_cnt SHALL increment on each accepted branch; mispred_cnt on each accepted mispredict; both wrap 0xFFFFFFFF -> 0.
REQ-032 Latency: accept to redirect_valid = 1 cycle; accept to BHT update = 1 edge.

Reset
REQ-033 During rst: redirect_valid=0, redirect_pc=0, flush=0, in_ready=1, both counters=0, all BHT entries=01 (weakly not-taken, lu_taken=0).
REQ-034 rst asserted mid-redirect SHALL drop redirect_valid immediately without a flush pulse.

Verification
REQ-035 After reset, in_branch=1, cond=001, zf=1, pc=0x100, target=0x200, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x200, in_ready=0; mispred_cnt=1.
REQ-036 cond=100, zf=0, lf=1, pc=0x100, pred_taken=1 -> redirect_pc=0x108; hold redirect_ready=0 for 3 cycles -> redirect_pc stable, in_valid ignored; redirect_ready=1 -> flush=1 one cycle.
REQ-037 Taken, correct-target prediction -> no redirect, branch_cnt=1, mispred_cnt=0; pred target 0x204 vs actual 0x200 -> redirect to 0x200.
REQ-038 Four taken branches at pc=0x40 -> counter 01->10->11->11; lu_pc=0x40 gives lu_taken=1 after the first update; two not-taken -> 01, lu_taken=0.
REQ-039 pc=0xFFFFFFFC not-taken mispredicted -> redirect_pc=0x00000004 (wrap).
REQ-040 rst pulse while redirect_valid=1 -> redirect_valid=0, flush=0, counters=0, lu_taken=0 for all indices.
